// File: rtl/amm2axi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : amm2axi_pipe
// Brief    : Pipelined Avalon-MM slave to AXI4-Lite master bridge with
//            configurable outstanding reads/writes and response return.
// Revision : 1.0
// ============================================================================
module amm2axi_pipe #(
    parameter int P_ASIZE  = 32,
    parameter int P_DBYTES = 4,
    parameter int P_MAXRD  = 4,
    parameter int P_MAXWR  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [P_ASIZE-1:0]    amm_address,
    input  logic [P_DBYTES*8-1:0] amm_writedata,
    input  logic [P_DBYTES-1:0]   amm_byteenable,
    input  logic                  amm_write,
    input  logic                  amm_read,
    output logic                  amm_waitrequest,
    output logic [P_DBYTES*8-1:0] amm_readdata,
    output logic                  amm_readdatavalid,
    output logic                  amm_writeresponsevalid,
    output logic [1:0]            amm_response,
    output logic [P_ASIZE-1:0]    axi_awaddr,
    output logic [2:0]            axi_awprot,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [P_DBYTES*8-1:0] axi_wdata,
    output logic [P_DBYTES-1:0]   axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [P_ASIZE-1:0]    axi_araddr,
    output logic [2:0]            axi_arsize,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [P_DBYTES*8-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    localparam int              c_rcw    = $clog2(P_MAXRD + 1);
    localparam int              c_wcw    = $clog2(P_MAXWR + 1);
    localparam logic [c_rcw-1:0] c_maxrd = c_rcw'(P_MAXRD);
    localparam logic [c_wcw-1:0] c_maxwr = c_wcw'(P_MAXWR);
    localparam logic [2:0]      c_arsize = 3'($clog2(P_DBYTES));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } dir_t;

    dir_t                  r_dir;
    dir_t                  w_dir_nxt;
    logic [c_rcw-1:0]      r_rd_cnt, w_rd_cnt_nxt;
    logic [c_wcw-1:0]      r_wr_cnt, w_wr_cnt_nxt;

    logic                  r_arvalid, r_awvalid, r_wvalid;
    logic [P_ASIZE-1:0]    r_araddr, r_awaddr;
    logic [P_DBYTES*8-1:0] r_wdata, r_readdata;
    logic [P_DBYTES-1:0]   r_wstrb;
    logic                  r_rready, r_bready;
    logic                  r_rdv, r_wrv;
    logic [1:0]            r_response;

    logic w_rd_ok, w_wr_ok, w_rd_acc, w_wr_acc, w_r_hs, w_b_hs;

    // Opposite direction must be fully drained; this is what keeps AMM
    // responses in issue order across a direction change.
    assign w_rd_ok  = (r_dir != S_WR) && (r_rd_cnt < c_maxrd) && (!r_arvalid || axi_arready);
    assign w_wr_ok  = (r_dir != S_RD) && (r_wr_cnt < c_maxwr)
                   && (!r_awvalid || axi_awready) && (!r_wvalid || axi_wready);
    assign w_wr_acc = amm_write && w_wr_ok;
    assign w_rd_acc = amm_read && !amm_write && w_rd_ok;
    assign amm_waitrequest = amm_write ? !w_wr_ok : !w_rd_ok;

    // Beats arriving with nothing outstanding are dropped.
    assign w_r_hs = axi_rvalid && r_rready && (r_rd_cnt != '0);
    assign w_b_hs = axi_bvalid && r_bready && (r_wr_cnt != '0);

    always_comb begin
        w_rd_cnt_nxt = r_rd_cnt;
        w_wr_cnt_nxt = r_wr_cnt;
        if (w_rd_acc && !w_r_hs)
            w_rd_cnt_nxt = r_rd_cnt + c_rcw'(1);
        else if (!w_rd_acc && w_r_hs)
            w_rd_cnt_nxt = r_rd_cnt - c_rcw'(1);
        if (w_wr_acc && !w_b_hs)
            w_wr_cnt_nxt = r_wr_cnt + c_wcw'(1);
        else if (!w_wr_acc && w_b_hs)
            w_wr_cnt_nxt = r_wr_cnt - c_wcw'(1);
        w_dir_nxt = S_IDLE;
        if (w_wr_cnt_nxt != '0)
            w_dir_nxt = S_WR;
        else if (w_rd_cnt_nxt != '0)
            w_dir_nxt = S_RD;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dir      <= S_IDLE;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_arvalid  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_araddr   <= '0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rready   <= 1'b0;
            r_bready   <= 1'b0;
            r_rdv      <= 1'b0;
            r_wrv      <= 1'b0;
            r_readdata <= '0;
            r_response <= 2'b00;
        end else begin
            r_rready <= 1'b1;
            r_bready <= 1'b1;
            r_dir    <= w_dir_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;

            if (w_rd_acc) begin
                r_arvalid <= 1'b1;
                r_araddr  <= amm_address;
            end else if (axi_arready) begin
                r_arvalid <= 1'b0;
            end

            // AW and W retire independently of each other.
            if (w_wr_acc) begin
                r_awvalid <= 1'b1;
                r_awaddr  <= amm_address;
                r_wvalid  <= 1'b1;
                r_wdata   <= amm_writedata;
                r_wstrb   <= amm_byteenable;
            end else begin
                if (axi_awready)
                    r_awvalid <= 1'b0;
                if (axi_wready)
                    r_wvalid <= 1'b0;
            end

            r_rdv <= w_r_hs;
            r_wrv <= w_b_hs;
            if (w_r_hs) begin
                r_readdata <= axi_rdata;
                r_response <= axi_rresp;
            end else if (w_b_hs) begin
                r_response <= axi_bresp;
            end
        end
    end

    assign amm_readdata           = r_readdata;
    assign amm_readdatavalid      = r_rdv;
    assign amm_writeresponsevalid = r_wrv;
    assign amm_response           = r_response;
    assign axi_awaddr             = r_awaddr;
    assign axi_awprot             = 3'b000;
    assign axi_awvalid            = r_awvalid;
    assign axi_wdata              = r_wdata;
    assign axi_wstrb              = r_wstrb;
    assign axi_wvalid             = r_wvalid;
    assign axi_bready             = r_bready;
    assign axi_araddr             = r_araddr;
    assign axi_arsize             = c_arsize;
    assign axi_arprot             = 3'b000;
    assign axi_arvalid            = r_arvalid;
    assign axi_rready             = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_amm2axi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_amm2axi_pipe
// Brief    : Self-checking bench for amm2axi_pipe: AMM master, AXI slave model
//            and a word-level memory/response reference.
// Revision : 1.0
// ============================================================================
module tb_amm2axi_pipe;
    localparam int P_ASIZE = 32, P_DBYTES = 4, P_MAXRD = 4, P_MAXWR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] amm_address, amm_writedata, amm_readdata;
    logic [3:0]  amm_byteenable;
    logic        amm_write, amm_read, amm_waitrequest, amm_readdatavalid, amm_writeresponsevalid;
    logic [1:0]  amm_response;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arsize, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [1:0]  axi_bresp, axi_rresp;

    amm2axi_pipe #(.P_ASIZE(P_ASIZE), .P_DBYTES(P_DBYTES), .P_MAXRD(P_MAXRD), .P_MAXWR(P_MAXWR)) dut (
        .clk(clk), .reset(reset),
        .amm_address(amm_address), .amm_writedata(amm_writedata), .amm_byteenable(amm_byteenable),
        .amm_write(amm_write), .amm_read(amm_read), .amm_waitrequest(amm_waitrequest),
        .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
        .amm_writeresponsevalid(amm_writeresponsevalid), .amm_response(amm_response),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arprot(axi_arprot),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word memory as seen by the AMM master, responses by region
    logic [31:0] ref_mem [int];
    logic [31:0] slv_mem [int];
    function automatic logic [31:0] init_word(input int idx);
        return (idx * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic logic [1:0] resp_for(input logic [31:0] a);
        if (a[11:8] == 4'hE) return 2'b10;
        if (a[11:8] == 4'hF) return 2'b11;
        return 2'b00;
    endfunction

    typedef struct packed {logic [31:0] data; logic [1:0] resp;} rd_exp_t;
    rd_exp_t     exp_rd[$];
    logic [1:0]  exp_b[$];
    logic [31:0] exp_ar[$], exp_aw[$];
    logic [35:0] exp_w[$];
    int rd_out = 0, wr_out = 0;

    // AXI slave model: per-channel ready delays and response latencies
    typedef struct {logic [31:0] data; logic [1:0] resp; int due;} rsp_t;
    rsp_t        slv_rq[$], slv_bq[$];
    logic [31:0] slv_awq[$];
    logic [35:0] slv_wq[$];
    int cfg_lo[5], cfg_hi[5];
    int ar_age = 0, aw_age = 0, w_age = 0, ar_wt = 0, aw_wt = 0, w_wt = 0;
    bit stale_r = 0;
    int rhs_log[$];

    function automatic int pick(input int i);
        return int'($urandom_range(cfg_hi[i], cfg_lo[i]));
    endfunction

    always @(negedge clk) begin
        logic [31:0] a, wd;
        logic [35:0] wv;
        rsp_t r;
        axi_arready = axi_arvalid && (ar_age >= ar_wt);
        axi_awready = axi_awvalid && (aw_age >= aw_wt);
        axi_wready  = axi_wvalid && (w_age >= w_wt);
        if (stale_r) begin
            axi_rvalid = 1'b1; axi_rdata = $urandom; axi_rresp = 2'b01;
        end else if (slv_rq.size() > 0 && slv_rq[0].due <= cyc) begin
            axi_rvalid = 1'b1; axi_rdata = slv_rq[0].data; axi_rresp = slv_rq[0].resp;
        end else begin
            axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
        end
        if (slv_bq.size() > 0 && slv_bq[0].due <= cyc) begin
            axi_bvalid = 1'b1; axi_bresp = slv_bq[0].resp;
        end else begin
            axi_bvalid = 1'b0; axi_bresp = 2'b00;
        end
        #2;
        if (axi_arvalid && axi_arready) begin
            chk("ar_expected", exp_ar.size() > 0, 1);
            if (exp_ar.size() > 0) chk("ar_addr", axi_araddr, exp_ar.pop_front());
            chk("ar_size", axi_arsize, 3'd2);
            chk("ar_prot", axi_arprot, 3'd0);
            chk("ar_no_wr_pending", wr_out, 0);
            a = axi_araddr >> 2;
            r.data = slv_mem.exists(int'(a)) ? slv_mem[int'(a)] : init_word(int'(a));
            r.resp = resp_for(axi_araddr);
            r.due  = cyc + 1 + pick(3);
            slv_rq.push_back(r);
            ar_age = 0; ar_wt = pick(0);
        end else if (axi_arvalid) ar_age++;
        if (axi_awvalid && axi_awready) begin
            chk("aw_expected", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) chk("aw_addr", axi_awaddr, exp_aw.pop_front());
            chk("aw_prot", axi_awprot, 3'd0);
            chk("aw_no_rd_pending", rd_out, 0);
            slv_awq.push_back(axi_awaddr);
            aw_age = 0; aw_wt = pick(1);
        end else if (axi_awvalid) aw_age++;
        if (axi_wvalid && axi_wready) begin
            chk("w_expected", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) chk("w_strb_data", {axi_wstrb, axi_wdata}, exp_w.pop_front());
            slv_wq.push_back({axi_wstrb, axi_wdata});
            w_age = 0; w_wt = pick(2);
        end else if (axi_wvalid) w_age++;
        while (slv_awq.size() > 0 && slv_wq.size() > 0) begin
            a  = slv_awq.pop_front();
            wv = slv_wq.pop_front();
            wd = slv_mem.exists(int'(a >> 2)) ? slv_mem[int'(a >> 2)] : init_word(int'(a >> 2));
            for (int b = 0; b < 4; b++) if (wv[32+b]) wd[8*b +: 8] = wv[8*b +: 8];
            slv_mem[int'(a >> 2)] = wd;
            r.data = '0; r.resp = resp_for(a); r.due = cyc + 1 + pick(4);
            slv_bq.push_back(r);
        end
        if (axi_rvalid && axi_rready && !stale_r && slv_rq.size() > 0) begin
            void'(slv_rq.pop_front());
            rd_out--;
            rhs_log.push_back(cyc);
        end
        if (axi_bvalid && axi_bready && slv_bq.size() > 0) begin
            void'(slv_bq.pop_front());
            wr_out--;
        end
    end

    // AMM response monitor
    int last_rdv_cyc = 0, rdv_cnt = 0, wrv_cnt = 0;
    always @(negedge clk) begin
        rd_exp_t e;
        #1;
        if (reset) begin
            if (amm_readdatavalid) begin
                rdv_cnt++; last_rdv_cyc = cyc;
                chk("rdv_expected", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    chk("rd_data", amm_readdata, e.data);
                    chk("rd_resp", amm_response, e.resp);
                end
            end
            if (amm_writeresponsevalid) begin
                wrv_cnt++;
                chk("wrv_expected", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) chk("wr_resp", amm_response, exp_b.pop_front());
            end
        end
    end

    task automatic set_cfg(input int arl, arh, awl, awh, wl, wh, rl, rh, bl, bh);
        #3;
        cfg_lo = '{arl, awl, wl, rl, bl};
        cfg_hi = '{arh, awh, wh, rh, bh};
        ar_wt = pick(0); aw_wt = pick(1); w_wt = pick(2);
    endtask

    task automatic amm_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            amm_read = 1'b0; amm_write = 1'b0;
        end
    endtask

    task automatic amm_cmd(input bit is_wr, input bit both, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, output int acc);
        int budget;
        logic [31:0] w;
        rd_exp_t e;
        budget = 0;
        @(negedge clk);
        amm_write = is_wr; amm_read = !is_wr || both;
        amm_address = addr; amm_writedata = data; amm_byteenable = be;
        #1;
        while (amm_waitrequest && budget < 200) begin
            @(negedge clk); #1; budget++;
        end
        chk("accept_in_time", budget < 200, 1);
        acc = cyc;
        if (budget >= 200) begin
            amm_read = 1'b0; amm_write = 1'b0; acc = -1;
        end else if (is_wr) begin
            chk("wr_acc_rd_drained", rd_out, 0);
            chk("wr_acc_limit", wr_out < P_MAXWR, 1);
            w = ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : init_word(int'(addr >> 2));
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[int'(addr >> 2)] = w;
            exp_aw.push_back(addr); exp_w.push_back({be, data}); exp_b.push_back(resp_for(addr));
            wr_out++;
        end else begin
            chk("rd_acc_wr_drained", wr_out, 0);
            chk("rd_acc_limit", rd_out < P_MAXRD, 1);
            e.data = ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : init_word(int'(addr >> 2));
            e.resp = resp_for(addr);
            exp_ar.push_back(addr); exp_rd.push_back(e);
            rd_out++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_rd.size() != 0 || exp_b.size() != 0 || rd_out != 0 || wr_out != 0) && n < 400) begin
            @(negedge clk); #3; n++;
        end
        chk(tag, n < 400, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, accw, base_rdv, base_wrv, sel;
        int accs[6];
        logic [31:0] ad;
        reset = 1'b0; amm_read = 1'b0; amm_write = 1'b0;
        amm_address = '0; amm_writedata = '0; amm_byteenable = '0;
        axi_arready = 0; axi_awready = 0; axi_wready = 0; axi_rvalid = 0; axi_bvalid = 0;
        axi_rdata = '0; axi_rresp = '0; axi_bresp = '0;
        cfg_lo = '{0, 0, 0, 0, 0}; cfg_hi = '{0, 0, 0, 0, 0};
        ref_mem[32'h1000 >> 2] = 32'hDEADBEEF;
        slv_mem[32'h1000 >> 2] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valids", {axi_arvalid, axi_awvalid, axi_wvalid, amm_readdatavalid,
                           amm_writeresponsevalid, axi_rready, axi_bready}, 7'd0);
        chk("rst_resp", amm_response, 2'b00);
        chk("rst_rdata", amm_readdata, 32'd0);
        chk("rst_wait", amm_waitrequest, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        chk("readies_up", {axi_bready, axi_rready}, 2'b11);

        // Single read, zero-wait slave
        base_rdv = rdv_cnt;
        amm_cmd(0, 0, 32'h1000, 0, 0, acc);
        amm_idle(1); #1;
        chk("single_arvalid", axi_arvalid, 1'b1);
        chk("single_araddr", axi_araddr, 32'h1000);
        drain("single_drain");
        chk("single_rdv_cnt", rdv_cnt - base_rdv, 1);
        chk("single_latency", last_rdv_cyc - acc, 3);

        // Zero-wait streaming: one read per cycle
        for (int i = 0; i < 6; i++) amm_cmd(0, 0, 32'h300 + 4 * i, 0, 0, accs[i]);
        amm_idle(1);
        chk("stream_rate", accs[5] - accs[0], 5);
        drain("stream_drain");

        // Six reads against a slow R channel: fifth stalls until first R
        set_cfg(0, 0, 0, 0, 0, 0, 10, 10, 0, 0);
        rhs_log.delete();
        base_rdv = rdv_cnt;
        for (int i = 0; i < 6; i++) amm_cmd(0, 0, 32'h100 + 4 * i, 0, 0, accs[i]);
        amm_idle(1);
        drain("slow_drain");
        chk("slow_first4", accs[3] - accs[0], 3);
        chk("slow_fifth_after_r", accs[4], rhs_log[0] + 1);
        chk("slow_fifth_gap", accs[4] - accs[0], 13);
        chk("slow_rdv_cnt", rdv_cnt - base_rdv, 6);

        // Write with W ready three cycles after AW
        set_cfg(0, 0, 0, 0, 3, 3, 0, 0, 0, 0);
        base_wrv = wrv_cnt;
        amm_cmd(1, 0, 32'h20, 32'h11223344, 4'h3, acc);
        amm_idle(1); #1;
        chk("wr_both_valid", {axi_awvalid, axi_wvalid}, 2'b11);
        amm_idle(1); #1;
        chk("wr_aw_first", {axi_awvalid, axi_wvalid}, 2'b01);
        drain("wr_drain");
        chk("wr_wrv_cnt", wrv_cnt - base_wrv, 1);

        // Read pending, then write held until the read data returns
        set_cfg(0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
        amm_cmd(0, 0, 32'h20, 0, 0, acc);
        amm_cmd(1, 0, 32'h44, 32'hCAFEF00D, 4'hF, accw);
        amm_idle(1);
        drain("switch_drain");
        chk("switch_wr_at_rdv", accw, last_rdv_cyc);

        // Error responses, and an illegal read+write (write wins)
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        amm_cmd(0, 0, 32'hE00, 0, 0, acc);
        amm_cmd(1, 0, 32'hF00, 32'h0BADC0DE, 4'hF, acc);
        amm_cmd(1, 1, 32'h48, 32'h55667788, 4'hC, acc);
        amm_idle(1);
        drain("err_drain");
        amm_cmd(0, 0, 32'h48, 0, 0, acc);
        amm_idle(1);
        drain("err_readback_drain");

        // Reset with three reads outstanding; stale R beats afterwards
        set_cfg(0, 0, 0, 0, 0, 0, 30, 30, 0, 0);
        for (int i = 0; i < 3; i++) amm_cmd(0, 0, 32'h200 + 4 * i, 0, 0, acc);
        amm_idle(2);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;
        chk("midrst_valids", {axi_arvalid, axi_awvalid, axi_wvalid, amm_readdatavalid,
                              amm_writeresponsevalid, axi_rready, axi_bready}, 7'd0);
        chk("midrst_wait", amm_waitrequest, 1'b0);
        #2;
        exp_rd.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_b.delete();
        slv_rq.delete(); slv_bq.delete(); slv_awq.delete(); slv_wq.delete();
        rd_out = 0; wr_out = 0;
        @(negedge clk); reset = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        base_rdv = rdv_cnt;
        stale_r = 1'b1;
        repeat (4) @(negedge clk);
        #3; stale_r = 1'b0;
        repeat (2) @(negedge clk);
        chk("stale_ignored", rdv_cnt - base_rdv, 0);
        amm_cmd(0, 0, 32'h1000, 0, 0, acc);
        amm_idle(1);
        drain("post_rst_drain");
        chk("post_rst_rdv", rdv_cnt - base_rdv, 1);

        // Randomized mixed traffic against the reference memory
        set_cfg(0, 3, 0, 3, 0, 3, 0, 4, 0, 4);
        for (int t = 0; t < 300; t++) begin
            sel = int'($urandom_range(9, 0));
            ad = {26'd0, 4'($urandom_range(15, 0)), 2'b00};
            if (sel == 8) ad = 32'hE00 | ad;
            if (sel == 9) ad = 32'hF00 | ad;
            amm_cmd(bit'($urandom_range(1, 0)), 0, ad, $urandom, 4'($urandom_range(15, 1)), acc);
            if ($urandom_range(3, 0) == 0) amm_idle(1);
        end
        amm_idle(1);
        drain("rand_drain");
        chk("rand_queues_empty", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/amm2axi_pipe.md
Name: amm2axi_pipe

Overview:
Pipelined Avalon-MM slave to AXI4-Lite master bridge, the next generation of the single-transaction AMM-to-AXI bridge. It supports a configurable number of outstanding reads and writes, returns read data on readdatavalid, and reports AXI responses back on the AMM response bus. It sits between AMM-mastering cores (CPU, DMA) and AXI4-Lite peripheral interconnect.

Parameters:
P_ASIZE, 32, address width in bits (byte addresses)
P_DBYTES, 4, data bus width in bytes (1, 2, 4 or 8)
P_MAXRD, 4, maximum outstanding reads (1..16)
P_MAXWR, 4, maximum outstanding writes (1..16)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
amm_address  in  P_ASIZE  byte address
amm_writedata  in  P_DBYTES*8  write data
amm_byteenable  in  P_DBYTES  byte lanes
amm_write  in  1  write command
amm_read  in  1  read command
amm_waitrequest  out  1  command stall
amm_readdata  out  P_DBYTES*8  read data
amm_readdatavalid  out  1  read data strobe
amm_writeresponsevalid  out  1  write response strobe
amm_response  out  2  AXI resp of the returned read or write
axi_awaddr/awprot/awvalid/awready  out/out/out/in  P_ASIZE/3/1/1  AW channel
axi_wdata/wstrb/wvalid/wready  out/out/out/in  P_DBYTES*8/P_DBYTES/1/1  W channel
axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel
axi_araddr/arsize/arprot/arvalid/arready  out/out/out/out/in  P_ASIZE/3/3/1/1  AR channel
axi_rdata/rresp/rvalid/rready  in/in/in/out  P_DBYTES*8/2/1/1  R channel

Behaviour:
- Reset (reset==0 at rising clk): all valids, readdatavalid, writeresponsevalid, bready, rready = 0; response, readdata = 0; counters rd_cnt, wr_cnt = 0; dir = idle. In-flight AXI responses are dropped; the AMM master must also be reset.
- arprot = awprot = 3'b000; arsize = log2(P_DBYTES); bready = rready = 1 whenever out of reset (outstanding limits guarantee sink capacity).
- Accept = (amm_read | amm_write) & !amm_waitrequest. Command is registered; AR, or AW and W, asserted the cycle after acceptance.
- Read accept allowed iff wr_cnt==0, rd_cnt<P_MAXRD (counting the read retiring this cycle), and (!arvalid | arready). Write accept allowed iff rd_cnt==0, wr_cnt<P_MAXWR, (!awvalid | awready) and (!wvalid | wready). amm_waitrequest is the negation for the requested direction. It has a combinational path from arready/awready/wready only.
- Direction switch: the block drains all outstanding transactions of one type before accepting the other, which keeps AMM response order.
- amm_read & amm_write both high is illegal; write is served and read ignored.
- AW and W are independent. Each valid drops on its own handshake, in any order; AW may complete before W or after it.
- rd_cnt: +1 on read accept, -1 on R handshake, unchanged if both occur. wr_cnt likewise with B handshake.
- R handshake at T: amm_readdata = rdata, amm_response = rresp, amm_readdatavalid = 1 at T+1 for one cycle.
- B handshake at T: amm_response = bresp, amm_writeresponsevalid = 1 at T+1 for one cycle. readdata holds its value.
- Minimum read latency with zero-wait slave: accept T, arvalid T+1, rvalid T+2, readdatavalid T+3. Sustained throughput is 1 read/cycle when P_MAXRD ≥ 3.
- R or B with no outstanding transaction is ignored and does not underflow the counter.
- SLVERR/DECERR are passed through unmodified. The transaction still completes.

Test Plan:
- Single read 0x1000, slave arready=1, rdata=0xDEADBEEF rresp=0 one cycle later -> araddr=0x1000 at T+1, readdatavalid with 0xDEADBEEF at T+3, response=0.
- 6 back-to-back reads, P_MAXRD=4, slave delays all R by 10 cycles -> waitrequest asserted on 5th read until first R; 6 readdatavalid pulses in order, data matching addresses.
- Write 0x20, data 0x11223344, be=0x3, wready 3 cycles after awready -> awvalid drops first, wstrb=0x3, single writeresponsevalid after bvalid with bresp=0.
- Read pending then write issued -> waitrequest held on write until readdatavalid of the read; awvalid asserted only after that.
- Slave returns rresp=2'b10 and bresp=2'b11 -> amm_response=2 with readdatavalid, then 3 with writeresponsevalid; counters return to 0.
- reset driven low with 3 reads outstanding -> next cycle all valids=0, waitrequest per idle state; after release a new read completes normally, and stale R beats are ignored.
